alu_arbiter: RTL

Shares the single 64-bit ALU between two independent requesters, e.g. the main execute datapath and a secondary address/debug unit. Round-robin arbitration with a valid/ready handshake on each request port. The granted operation is registered into a two-stage pipeline: operand register, then ALU, then result register. Each result is routed back to the requester that issued it, one operation accepted per cycle.

---
 rtl/alu_arbiter_if.sv | 41 ++++
 rtl/alu_arbiter.sv | 91 +++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two ALU requesters and alu_arbiter.
// The master modport is the requester side; the slave modport is the arbiter side.
interface alu_arbiter_if #(
  parameter int N = 64
);
  logic         req0_valid;
  logic         req0_ready;
  logic [N-1:0] req0_a;
  logic [N-1:0] req0_b;
  logic [3:0]   req0_ctl;
  logic         req1_valid;
  logic         req1_ready;
  logic [N-1:0] req1_a;
  logic [N-1:0] req1_b;
  logic [3:0]   req1_ctl;
  logic         rsp0_valid;
  logic [N-1:0] rsp0_result;
  logic         rsp0_zero;
  logic         rsp1_valid;
  logic [N-1:0] rsp1_result;
  logic         rsp1_zero;
  logic         busy;

  modport master (
    output req0_valid, req0_a, req0_b, req0_ctl,
    output req1_valid, req1_a, req1_b, req1_ctl,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_result, rsp0_zero,
    input  rsp1_valid, rsp1_result, rsp1_zero,
    input  busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ctl,
    input  req1_valid, req1_a, req1_b, req1_ctl,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_result, rsp0_zero,
    output rsp1_valid, rsp1_result, rsp1_zero,
    output busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one N-bit ALU between two requesters, with an
// operand register stage and a result register stage routed back by owner.
module alu_arbiter #(
  parameter int N = 64
) (
  input  logic clk,
  input  logic reset,
  alu_arbiter_if.slave bus
);

  logic         last;
  logic         s1_valid;
  logic         s1_owner;
  logic [N-1:0] s1_a;
  logic [N-1:0] s1_b;
  logic [3:0]   s1_ctl;
  logic         s2_valid;
  logic         s2_owner;
  logic [N-1:0] s2_result;
  logic         s2_zero;

  logic         grant0;
  logic         grant1;
  logic [N-1:0] alu_result;
  logic         alu_zero;

  // last==1 means requester 1 was granted most recently, so requester 0 wins a tie
  always_comb begin
    grant0 = !reset && bus.req0_valid && (!bus.req1_valid || last);
    grant1 = !reset && bus.req1_valid && (!bus.req0_valid || !last);
  end

  always_comb begin
    alu_result = '0;
    unique case (s1_ctl)
      4'b0000: alu_result = s1_a & s1_b;
      4'b0001: alu_result = s1_a | s1_b;
      4'b0010: alu_result = s1_a + s1_b;
      4'b0110: alu_result = s1_a - s1_b;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last      <= 1'b1;
      s1_valid  <= 1'b0;
      s1_owner  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_ctl    <= '0;
      s2_valid  <= 1'b0;
      s2_owner  <= 1'b0;
      s2_result <= '0;
      s2_zero   <= 1'b0;
    end else begin
      s1_valid <= grant0 | grant1;
      if (grant0) begin
        s1_owner <= 1'b0;
        s1_a     <= bus.req0_a;
        s1_b     <= bus.req0_b;
        s1_ctl   <= bus.req0_ctl;
        last     <= 1'b0;
      end else if (grant1) begin
        s1_owner <= 1'b1;
        s1_a     <= bus.req1_a;
        s1_b     <= bus.req1_b;
        s1_ctl   <= bus.req1_ctl;
        last     <= 1'b1;
      end
      s2_valid  <= s1_valid;
      s2_owner  <= s1_owner;
      s2_result <= alu_result;
      s2_zero   <= alu_zero;
    end
  end

  always_comb begin
    bus.req0_ready  = grant0;
    bus.req1_ready  = grant1;
    bus.rsp0_valid  = s2_valid && !s2_owner;
    bus.rsp1_valid  = s2_valid && s2_owner;
    bus.rsp0_result = s2_result;
    bus.rsp1_result = s2_result;
    bus.rsp0_zero   = s2_zero;
    bus.rsp1_zero   = s2_zero;
    bus.busy        = s1_valid | s2_valid;
  end

endmodule
